dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the four byte-lane data-memory banks between two requesters: the pipeline MEM stage (port A) and a loader/DMA master (port B, e.g. the UART program loader). Port A has fixed priority, with a starvation counter that guarantees port B forward progress, and port B can lock the memory for bursts. The block drives the bank address, per-lane write enables and write data, tracks which port owns the synchronous read return, and raises a stall toward the pipeline when port A is not granted.

## Interface
- MAX_WAIT, 4: cycles port B may be refused while requesting before it gets priority; legal range 1..15.
- ADDR_LIMIT, 32'h0000_0FFF: highest legal byte address. Accesses above it perform no write and read back zero.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block.
- a_req  in  1  port A access request.
- a_we  in  4  port A byte-lane write enables; 4'b0000 means read.
- a_addr  in  32  port A byte address.
- a_wdata  in  32  port A lane-aligned write data.
- a_gnt  out  1  port A access issued this cycle (combinational).
- a_stall  out  1  a_req & ~a_gnt; freezes the pipeline.
- a_rvalid  out  1  port A read data valid (registered).
- a_rdata  out  32  port A read data.
- a_err  out  1  one-cycle pulse: previous port A access was out of range.
- b_req, b_we[3:0], b_addr[31:0], b_wdata[31:0], b_lock (1)  in: port B equivalents of the port A inputs; b_lock requests burst ownership.
- b_gnt, b_rvalid, b_rdata[31:0], b_err  out: port B equivalents of the port A outputs.
- dmem_addr  out  32  address to all four banks.
- dmem_we  out  4  per-bank write enable.
- dmem_wr_data  out  32  bytes to banks 3..0.
- dmem_rd_data  in  32  bank read data, valid the cycle after dmem_addr is presented.

## Operation
- At most one access is issued per cycle. The issued access drives dmem_addr, dmem_we and dmem_wr_data from the granted port.
- When no grant is made: dmem_we=0, dmem_addr=0, dmem_wr_data=0.
- Out of range (addr > ADDR_LIMIT):
  - dmem_we is forced to 0.
  - The grant is still given.
  - err pulses the next cycle.
  - A read still returns rvalid, with rdata forced to 0.
- State machine states: A_PRIO, B_PRIO, B_LOCK. Reset state is A_PRIO.
- A_PRIO:
  - If a_req is high, A is granted. Otherwise B is granted if b_req is high.
  - If b_req is high and B is not granted, wait_cnt increments, saturating at MAX_WAIT. When the incremented value equals MAX_WAIT, the next state is B_PRIO.
  - When B is granted, wait_cnt clears. If b_lock is also high, the next state is B_LOCK.
- B_PRIO:
  - If b_req is high, B is granted even when a_req is high, and wait_cnt clears.
  - If b_lock is high at that grant, the next state is B_LOCK; otherwise the next state is A_PRIO.
  - If b_req is low, A is granted if it requests, and the next state is A_PRIO.
- B_LOCK:
  - Only B can be granted; a_gnt=0.
  - The state holds while b_lock is high.
  - If b_lock is low, the cycle is arbitrated as in A_PRIO and the next state is A_PRIO.
- Read return:
  - A granted read (we==0) sets the registered owner flag, so that port's rvalid is high the next cycle.
  - rdata = dmem_rd_data while rvalid is high and the access was in range; otherwise rdata=0.
  - Writes never produce rvalid.
- wait_cnt is 4 bits wide.

## Timing
- Grant is combinational: a_gnt/b_gnt rise in the same cycle as req.
- Read latency: rvalid and rdata appear exactly 1 cycle after the grant cycle. Back-to-back reads, including alternating ports, return every cycle in order.
- Write: the bank captures the data at the edge ending the grant cycle.
- While rst==0:
  - a_gnt, b_gnt and a_stall are 0 (a_stall stays 0 even if a_req is high).
  - dmem_we is 0.
- After the reset edge, these registered outputs are 0: rvalid, rdata, err, wait_cnt, lock state.
- Reset mid-operation: a pending read return is discarded and no rvalid is produced. A lock is released.
- Simultaneous requests in A_PRIO with wait_cnt < MAX_WAIT: A wins and a_stall=0.

## Test plan
- Reset: hold rst=0 for 3 cycles with a_req=b_req=1 -> both gnt=0 and dmem_we=0. After release, the first cycle gives a_gnt=1.
- A reads 0x10 after a write of 32'hDEADBEEF with we=4'b1111 -> a_rvalid=1 one cycle after the read grant, a_rdata=32'hDEADBEEF, b_rvalid=0.
- Starvation: a_req and b_req high continuously, MAX_WAIT=4 -> A granted in 4 cycles, then B granted in the 5th (a_stall=1 that cycle), then A again.
- Lock: B granted with b_lock=1, b_lock held 6 cycles while a_req=1 -> b_gnt for all 6 cycles, a_stall=1 throughout, A granted in the first cycle after b_lock falls.
- Out of range: A writes 0x2000 with ADDR_LIMIT=0xFFF -> dmem_we=0 and a_err pulses the next cycle. A subsequent read of 0x2000 gives a_rdata=0 with a_rvalid=1.
- Reset during return: B read granted, rst=0 at the next edge -> b_rvalid stays 0 and the owner flag clears.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the byte-lane data memory: A has priority, B has starvation relief and burst lock.
// Grant is same-cycle; read data returns one cycle after grant; port A stalls whenever it is refused.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [3:0]  a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_stall,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [3:0]  b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wr_data,
  input  logic [31:0] dmem_rd_data
);

  typedef enum logic [1:0] {A_PRIO, B_PRIO, B_LOCK} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic [3:0]  w_wait_inc;
  logic        w_sel_a;
  logic        w_sel_b;
  logic        r_a_rvalid;
  logic        r_b_rvalid;
  logic        r_a_err;
  logic        r_b_err;
  logic [31:0] w_addr;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic        w_oor;

  assign w_wait_inc = (r_wait_cnt < MAX_W) ? r_wait_cnt + 4'd1 : r_wait_cnt;

  always_comb begin
    w_sel_a     = 1'b0;
    w_sel_b     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (r_state == B_PRIO) begin
      if (b_req) begin
        w_sel_b     = 1'b1;
        w_wait_nxt  = 4'd0;
        w_state_nxt = b_lock ? B_LOCK : A_PRIO;
      end else begin
        w_sel_a     = a_req;
        w_state_nxt = A_PRIO;
      end
    end else if (r_state == B_LOCK && b_lock) begin
      w_sel_b     = b_req;
      w_state_nxt = B_LOCK;
    end else begin
      // A_PRIO rules; an unlocking B_LOCK cycle uses them too but always returns to A_PRIO
      w_sel_a     = a_req;
      w_sel_b     = ~a_req & b_req;
      w_state_nxt = A_PRIO;
      if (w_sel_b) begin
        w_wait_nxt = 4'd0;
        if (b_lock) w_state_nxt = B_LOCK;
      end else if (b_req) begin
        w_wait_nxt = w_wait_inc;
        if (w_wait_inc == MAX_W && r_state == A_PRIO) w_state_nxt = B_PRIO;
      end
    end
  end

  assign a_gnt   = rst & w_sel_a;
  assign b_gnt   = rst & w_sel_b;
  assign a_stall = rst & a_req & ~w_sel_a;

  always_comb begin
    w_addr  = 32'd0;
    w_we    = 4'd0;
    w_wdata = 32'd0;
    if (a_gnt) begin
      w_addr  = a_addr;
      w_we    = a_we;
      w_wdata = a_wdata;
    end else if (b_gnt) begin
      w_addr  = b_addr;
      w_we    = b_we;
      w_wdata = b_wdata;
    end
  end

  assign w_oor        = w_addr > ADDR_LIMIT;
  assign dmem_addr    = w_addr;
  assign dmem_we      = w_oor ? 4'd0 : w_we;
  assign dmem_wr_data = w_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= A_PRIO;
      r_wait_cnt <= 4'd0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_a_rvalid <= a_gnt & (a_we == 4'd0);
      r_b_rvalid <= b_gnt & (b_we == 4'd0);
      r_a_err    <= a_gnt & w_oor;
      r_b_err    <= b_gnt & w_oor;
    end
  end

  // the err flag doubles as the "zero the read data" marker for the returning access
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_err    = r_a_err;
  assign b_err    = r_b_err;
  assign a_rdata  = (r_a_rvalid && !r_a_err) ? dmem_rd_data : 32'd0;
  assign b_rdata  = (r_b_rvalid && !r_b_err) ? dmem_rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a bank model and per-port read-return scoreboards.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req, b_lock;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_stall, a_rvalid, a_err;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
  logic [3:0]  dmem_we;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] bank    [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_LIMIT(32'h0000_0FFF)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wr_data(dmem_wr_data),
    .dmem_rd_data(dmem_rd_data)
  );

  // synchronous byte-lane banks: read data valid the cycle after the address
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (dmem_we[l]) bank[dmem_addr[11:2]][8*l +: 8] <= dmem_wr_data[8*l +: 8];
    dmem_rd_data <= bank[dmem_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
      else chk("a_rdata", a_rdata, a_q.pop_front());
    end
    if (b_rvalid) begin
      if (b_q.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
      else chk("b_rdata", b_rdata, b_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
  endtask

  task automatic set_a(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    return (addr > 32'h0000_0FFF) ? 32'd0 : ref_mem[addr[11:2]];
  endfunction

  task automatic ref_wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    if (addr <= 32'h0000_0FFF)
      for (int l = 0; l < 4; l++)
        if (we[l]) ref_mem[addr[11:2]][8*l +: 8] = wd[8*l +: 8];
  endtask

  task automatic commit_a();
    if (a_we == 4'd0) a_q.push_back(exp_rd(a_addr));
    else ref_wr(a_addr, a_we, a_wdata);
  endtask

  task automatic commit_b();
    if (b_we == 4'd0) b_q.push_back(exp_rd(b_addr));
    else ref_wr(b_addr, b_we, b_wdata);
  endtask

  task automatic exp_gnt(input string tag, input logic ga, input logic gb, input logic st);
    chk({tag, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, ga});
    chk({tag, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, gb});
    chk({tag, "_a_stall"}, {31'd0, a_stall}, {31'd0, st});
  endtask

  // single-port access that must be granted immediately
  task automatic solo_a(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    idle(); set_a(we, addr, wd);
    mid(); exp_gnt("solo_a", 1, 0, 0); commit_a();
    tick();
  endtask

  task automatic solo_b(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    idle(); set_b(we, addr, wd);
    mid(); exp_gnt("solo_b", 0, 1, 0); commit_b();
    tick();
  endtask

  logic exp_a_seq [6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    rst = 0;
    idle();
    set_a(4'hF, 32'h40, 32'h0BAD_F00D);
    set_b(4'hF, 32'h44, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      mid();
      exp_gnt("rst_hold", 0, 0, 0);
      chk("rst_dmem_we", {28'd0, dmem_we}, 32'd0);
      if (i > 0) begin
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_err", {31'd0, b_err}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
      end
      tick();
    end
    rst = 1;
    mid(); exp_gnt("rst_release", 1, 0, 0); commit_a();
    tick();

    // B alone: granted, clears the wait counter
    solo_b(4'h0, 32'h40, 32'd0);

    // write then read through port A
    idle(); set_a(4'hF, 32'h10, 32'hDEAD_BEEF);
    mid();
    chk("wr_dmem_we", {28'd0, dmem_we}, 32'hF);
    chk("wr_dmem_addr", dmem_addr, 32'h10);
    chk("wr_dmem_data", dmem_wr_data, 32'hDEAD_BEEF);
    commit_a();
    tick();
    solo_a(4'h0, 32'h10, 32'd0);
    idle();
    mid();
    chk("rd_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("rd_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("idle_dmem_addr", dmem_addr, 32'd0);
    chk("idle_dmem_wr_data", dmem_wr_data, 32'd0);
    tick();

    // partial lane write and alternating back-to-back reads
    solo_b(4'hF, 32'h14, 32'hAABB_CCDD);
    solo_a(4'b0011, 32'h14, 32'h1122_3344);
    solo_a(4'hF, 32'h0, 32'h1234_5678);
    solo_a(4'hF, 32'hFFC, 32'hCAFE_0FFC);
    solo_a(4'h0, 32'h14, 32'd0);
    solo_b(4'h0, 32'h10, 32'd0);
    solo_a(4'h0, 32'h10, 32'd0);
    solo_b(4'h0, 32'h14, 32'd0);

    // starvation: A wins MAX_WAIT times, then B once, then A again
    idle(); set_a(4'h0, 32'h10, 32'd0); set_b(4'h0, 32'h14, 32'd0);
    for (int i = 0; i < 6; i++) begin
      mid();
      exp_gnt($sformatf("starve%0d", i), exp_a_seq[i], !exp_a_seq[i], !exp_a_seq[i]);
      if (exp_a_seq[i]) commit_a(); else commit_b();
      tick();
    end

    // burst lock: B holds the memory while A stalls
    idle(); set_b(4'h0, 32'h10, 32'd0); b_lock = 1;
    mid(); exp_gnt("lock_take", 0, 1, 0); commit_b();
    tick();
    set_a(4'h0, 32'h14, 32'd0);
    for (int i = 0; i < 6; i++) begin
      mid(); exp_gnt($sformatf("lock%0d", i), 0, 1, 1); commit_b();
      tick();
    end
    b_lock = 0; b_req = 0;
    mid(); exp_gnt("lock_drop", 1, 0, 0); commit_a();
    tick();

    // out-of-range: write suppressed, err pulses, reads return zero
    idle(); set_a(4'hF, 32'h2000, 32'h5555_5555);
    mid(); exp_gnt("oor_wr", 1, 0, 0);
    chk("oor_dmem_we", {28'd0, dmem_we}, 32'd0);
    tick();
    idle();
    mid(); chk("oor_err_pulse", {31'd0, a_err}, 32'd1);
    tick();
    mid(); chk("oor_err_clear", {31'd0, a_err}, 32'd0);
    tick();
    solo_a(4'h0, 32'h2000, 32'd0);
    idle();
    mid(); chk("oor_rd_err", {31'd0, a_err}, 32'd1);
    tick();
    solo_a(4'h0, 32'h1000, 32'd0);
    solo_a(4'h0, 32'hFFC, 32'd0);
    solo_b(4'h0, 32'h1000, 32'd0);
    idle();
    mid(); chk("oor_b_err", {31'd0, b_err}, 32'd1);
    tick();
    solo_a(4'h0, 32'h0, 32'd0);

    // reset right after a locked B read grant: return discarded, lock released
    idle(); set_b(4'h0, 32'h10, 32'd0); b_lock = 1;
    mid(); exp_gnt("rr_grant", 0, 1, 0);
    #1 rst = 0;
    tick();
    mid();
    chk("rr_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    exp_gnt("rr_in_reset", 0, 0, 0);
    tick();
    rst = 1;
    set_a(4'h0, 32'h10, 32'd0);
    mid(); exp_gnt("rr_unlocked", 1, 0, 0); commit_a();
    tick();

    idle();
    repeat (3) tick();
    chk("a_q_drained", a_q.size(), 32'd0);
    chk("b_q_drained", b_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
